nibble_serializer: RTL and testbench
====================================

Name: nibble_serializer

Overview:
- Transmit-side counterpart of the nibble-serial ALU datapath.
- Accepts whole words over a valid/ready handshake and emits them as a 4-bit nibble stream, one nibble per cycle, LSB nibble first, with index and last markers.
- Sits between register-file/fetch logic and any nibble-serial consumer.
- Double-buffered: a new word can be accepted while the current one is still shifting out, so back-to-back words stream with no bubble.

Parameters:
NIBBLES, 8, number of nibbles per word; word width is 4*NIBBLES; must be >= 2.
IDX_W, $clog2(NIBBLES), width of the nibble index.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset; low clears all state immediately.
word_data  in  4*NIBBLES  word to transmit.
word_valid  in  1  word_data is valid.
word_ready  out  1  block can accept a word this cycle.
nib_data  out  4  current nibble.
nib_idx  out  IDX_W  position of nib_data within its word.
nib_last  out  1  nib_data is the final nibble of its word.
nib_valid  out  1  nib_data/nib_idx/nib_last are valid.
nib_ready  in  1  consumer takes the nibble this cycle.

Behaviour:
- Storage: cur_word + cur_valid + idx counter (active word); pend_word + pend_valid (one-word holding buffer).
- State encoding (derived from valid bits):
  - EMPTY: cur_valid=0.
  - BUSY: cur_valid=1, pend_valid=0.
  - FULL: cur_valid=1, pend_valid=1.
- Reset values (asserted low, async): cur_valid=0, pend_valid=0, idx=0, nib_valid=0, nib_last=0, nib_idx=0, nib_data=0, word_ready=1.
  - Reset mid-word drops the current and pending words.
  - After reset release, the first word starts at idx 0.
- word_ready = !pend_valid (combinational from registers only; never depends on word_valid).
- nib_valid = cur_valid.
- nib_data = nibble idx of cur_word.
- nib_idx = idx.
- nib_last = cur_valid && idx==NIBBLES-1.
- Outputs are registered-state driven only; no combinational path from nib_ready to nib_valid/nib_data.
- Word accept: word_valid && word_ready.
- Nibble transfer: nib_valid && nib_ready.
  - If not last: idx <= idx+1, word held.
  - If last: idx <= 0, then:
    - pend_valid: cur_word <= pend_word, pend_valid <= 0 (FULL->BUSY).
    - else word accept this cycle: cur_word <= word_data (BUSY->BUSY, no bubble).
    - else: cur_valid <= 0 (BUSY->EMPTY).
- Word accept without a last-nibble transfer:
  - EMPTY: load cur, idx <= 0 (EMPTY->BUSY). The first nibble appears the next cycle; latency is 1 cycle.
  - BUSY: load pend (BUSY->FULL).
- FULL plus last transfer: word_ready is 0, so no simultaneous accept; pend moves to cur.
- nib_ready low: all outputs hold stable; idx does not advance.
- nib_valid is never withdrawn before transfer.
- Throughput: 1 nibble per cycle sustained; a word every NIBBLES cycles with nib_ready tied high.
- Index wrap: idx counts 0..NIBBLES-1 and returns to 0 only on a last transfer; it never reaches NIBBLES.

Optional Feature:
NIBBLE_SER_MSB_FIRST_EN
- Defined: nibbles are emitted MSB first; nib_data = nibble (NIBBLES-1-idx) of cur_word. nib_idx still counts 0 up, and nib_last is unchanged.
- Undefined (default): LSB-first order as above.

Decomposition:
- Package nibble_pkg:
  - localparam NIBBLE_W=4.
  - typedef logic[NIBBLE_W-1:0] nibble_t.
  - typedef enum {SER_EMPTY, SER_BUSY, SER_FULL} ser_state_e, used for debug/assertion visibility.
- Sub-module nibble_sel: parameterized NIBBLES combinational word-to-nibble selector (word, index -> nibble_t).
  - Instantiated once; it receives the reversed index when NIBBLE_SER_MSB_FIRST_EN is defined.

Test Plan:
- Reset then idle: word_valid=0 -> nib_valid=0, word_ready=1; reset asserted mid-word (after idx=3) -> nib_valid drops without waiting for a clock edge, and the next word starts at idx 0.
- Single word 32'h_8765_4321, nib_ready=1 -> 1 cycle later nib_data 1,2,3,4,5,6,7,8 on consecutive cycles, nib_last only with 8 at idx 7, then nib_valid=0.
- Back-to-back words 32'h_efff_ffff then 32'h_0000_0001 offered continuously -> 16 consecutive valid nibbles with no gap; the second word is accepted into pend, and word_ready=0 from then until its nibble 0 is emitted.
- Backpressure: nib_ready toggled 1,0,0,1,... on word 32'h_a5a5_a5a5 -> data/idx held while ready is low, sequence 5,a,5,a,... intact, no nibble duplicated or dropped.
- FULL boundary: cur + pend occupied, third word_valid held high -> word_ready=0 until the last nibble of the first word transfers; the third word is accepted the cycle after.
- NIBBLE_SER_MSB_FIRST_EN defined, word 32'h_8765_4321 -> nib_data 8,7,6,5,4,3,2,1 with nib_idx 0..7.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared types for the nibble-serial datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: NIBBLE_W, nibble_t, ser_state_e (serializer occupancy, derived from valid bits).
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Occupancy of the serializer: EMPTY (no word), BUSY (shifting, holding
  // buffer free), FULL (shifting, holding buffer occupied).
  typedef enum logic [1:0] {
    SER_EMPTY = 2'd0,
    SER_BUSY  = 2'd1,
    SER_FULL  = 2'd2
  } ser_state_e;

endpackage

// File: rtl/nibble_sel.sv
// Combinational word-to-nibble selector.
// Latency: 0 cycles (pure mux).
// Backpressure: none; output follows inputs.
// Ports: word (NIBBLES nibbles packed LSB-first), idx (nibble position), nib (selected nibble).
module nibble_sel
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 8,
  parameter int IDX_W   = $clog2(NIBBLES)
) (
  input  logic [NIBBLE_W*NIBBLES-1:0] word,
  input  logic [IDX_W-1:0]            idx,
  output nibble_t                     nib
);

  // Explicit compare-per-position mux; stays well defined for non power-of-2
  // NIBBLES where idx can encode positions past the top of the word.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        nib = word[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Double-buffered word-to-nibble serializer: one nibble per cycle, index and last markers.
// Latency: first nibble 1 cycle after word accept; back-to-back words stream with no bubble.
// Backpressure: nib_ready low freezes all nibble outputs; word_ready low only while the holding buffer is full.
// Ports: clk, reset (async active-low), word_data/word_valid/word_ready (word input),
//        nib_data/nib_idx/nib_last/nib_valid/nib_ready (nibble stream output).
// Build option: NIBBLE_SER_MSB_FIRST_EN emits the MSB nibble first; nib_idx still counts 0 up.
module nibble_serializer
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 8,
  parameter int IDX_W   = $clog2(NIBBLES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NIBBLE_W*NIBBLES-1:0] word_data,
  input  logic                        word_valid,
  output logic                        word_ready,
  output nibble_t                     nib_data,
  output logic [IDX_W-1:0]            nib_idx,
  output logic                        nib_last,
  output logic                        nib_valid,
  input  logic                        nib_ready
);

  localparam int              WORD_W   = NIBBLE_W * NIBBLES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // Active word being shifted out, plus a one-word holding buffer.
  logic [WORD_W-1:0] cur_word_q, cur_word_d;
  logic [WORD_W-1:0] pend_word_q, pend_word_d;
  logic              cur_valid_q, cur_valid_d;
  logic              pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic              at_last;
  logic              nib_xfer;
  logic              word_acc;
  logic [IDX_W-1:0]  sel_idx;
  ser_state_e        state;

  // Occupancy view of the valid bits, for assertions and debug.
  always_comb begin
    state = SER_EMPTY;
    if (cur_valid_q && pend_valid_q) begin
      state = SER_FULL;
    end else if (cur_valid_q) begin
      state = SER_BUSY;
    end
  end

  // All outputs come from registered state only; nib_ready never reaches them
  // combinationally, and word_ready never depends on word_valid.
  assign word_ready = !pend_valid_q;
  assign nib_valid  = cur_valid_q;
  assign nib_idx    = idx_q;
  assign at_last    = (idx_q == LAST_IDX);
  assign nib_last   = cur_valid_q && at_last;

  assign nib_xfer   = cur_valid_q && nib_ready;
  assign word_acc   = word_valid && word_ready;

`ifdef NIBBLE_SER_MSB_FIRST_EN
  assign sel_idx = LAST_IDX - idx_q;
`else
  assign sel_idx = idx_q;
`endif

  nibble_sel #(
    .NIBBLES (NIBBLES),
    .IDX_W   (IDX_W)
  ) u_sel (
    .word (cur_word_q),
    .idx  (sel_idx),
    .nib  (nib_data)
  );

  // Next-state logic.
  always_comb begin
    cur_word_d   = cur_word_q;
    pend_word_d  = pend_word_q;
    cur_valid_d  = cur_valid_q;
    pend_valid_d = pend_valid_q;
    idx_d        = idx_q;

    if (nib_xfer && at_last) begin
      // Word boundary: refill from the holding buffer first, else straight
      // from the input so a continuously offered stream has no bubble.
      // word_ready is low whenever pend is valid, so both branches never collide.
      idx_d = '0;
      if (pend_valid_q) begin
        cur_word_d   = pend_word_q;
        pend_valid_d = 1'b0;
      end else if (word_acc) begin
        cur_word_d = word_data;
      end else begin
        cur_valid_d = 1'b0;
      end
    end else begin
      if (nib_xfer) begin
        idx_d = idx_q + 1'b1;
      end
      if (word_acc) begin
        if (!cur_valid_q) begin
          cur_word_d  = word_data;
          cur_valid_d = 1'b1;
          idx_d       = '0;
        end else begin
          pend_word_d  = word_data;
          pend_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_word_q   <= '0;
      pend_word_q  <= '0;
      cur_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      idx_q        <= '0;
    end else begin
      cur_word_q   <= cur_word_d;
      pend_word_q  <= pend_word_d;
      cur_valid_q  <= cur_valid_d;
      pend_valid_q <= pend_valid_d;
      idx_q        <= idx_d;
    end
  end

  // The holding buffer is only ever filled behind an active word.
  a_pend_implies_cur: assert property (@(posedge clk) disable iff (!reset)
    pend_valid_q |-> cur_valid_q);

  // Index never runs past the last nibble.
  a_idx_range: assert property (@(posedge clk) disable iff (!reset)
    idx_q <= LAST_IDX);

  a_full_blocks_input: assert property (@(posedge clk) disable iff (!reset)
    (state == SER_FULL) |-> !word_ready);

  a_empty_no_output: assert property (@(posedge clk) disable iff (!reset)
    (state == SER_EMPTY) |-> !nib_valid);

  // A stalled nibble stays put until it is taken.
  a_hold_when_stalled: assert property (@(posedge clk) disable iff (!reset)
    (nib_valid && !nib_ready) |=> (nib_valid && $stable(nib_data) && $stable(nib_idx)));

endmodule

// File: tb/tb_nibble_serializer.sv
module tb_nibble_serializer;

  localparam int NIBBLES = 8;
  localparam int IDX_W   = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        word_data;
  logic               word_valid;
  logic               word_ready;
  logic [3:0]         nib_data;
  logic [IDX_W-1:0]   nib_idx;
  logic               nib_last;
  logic               nib_valid;
  logic               nib_ready;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  int xfer_cnt = 0;

  typedef struct packed {
    logic [3:0]       d;
    logic [IDX_W-1:0] i;
    logic             l;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t mon_p;

  always #5 clk = ~clk;

  nibble_serializer #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .nib_data   (nib_data),
    .nib_idx    (nib_idx),
    .nib_last   (nib_last),
    .nib_valid  (nib_valid),
    .nib_ready  (nib_ready)
  );

  // Reference nibble order for the build being simulated.
  function automatic logic [3:0] exp_nib(input logic [31:0] w, input int i);
`ifdef NIBBLE_SER_MSB_FIRST_EN
    return w[4*(NIBBLES-1-i) +: 4];
`else
    return w[4*i +: 4];
`endif
  endfunction

  // Scoreboard: words are expanded into expected nibbles on accept, and
  // popped on every nibble transfer. Pop before push keeps word order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (nib_valid && nib_ready) begin
        xfer_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got data=%h idx=%0d last=%0b, required no transfer", nib_data, nib_idx, nib_last);
        end else begin
          mon_e = sb_q.pop_front();
          if ({nib_data, nib_idx, nib_last} !== mon_e) begin
            failures++;
            $display("FAIL sb_nibble: got data=%h idx=%0d last=%0b, required data=%h idx=%0d last=%0b",
                     nib_data, nib_idx, nib_last, mon_e.d, mon_e.i, mon_e.l);
          end
        end
      end
      if (word_valid && word_ready) begin
        for (int i = 0; i < NIBBLES; i++) begin
          mon_p.d = exp_nib(word_data, i);
          mon_p.i = IDX_W'(i);
          mon_p.l = (i == NIBBLES-1);
          sb_q.push_back(mon_p);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers words back to back; returns 1 ns after the last one is accepted.
  task automatic drive_words(input logic [31:0] ws[$]);
    bit acc;
    @(posedge clk);
    #1;
    foreach (ws[n]) begin
      word_data  = ws[n];
      word_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (word_ready) begin
          acc = 1'b1;
          break;
        end
      end
      checks++;
      if (!acc) begin
        failures++;
        $display("FAIL word_accept_timeout: word %h got word_ready=0 for 40 cycles, required accept", ws[n]);
      end
      @(posedge clk);
      #1;
    end
    word_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!nib_valid && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    nib_ready  = 1'b0;
    #2;
    checks++;
    if ({nib_valid, nib_last, nib_idx, nib_data} !== 9'h0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%0b last=%0b idx=%0d data=%h, required all 0", nib_valid, nib_last, nib_idx, nib_data);
    end
    checks++;
    if (word_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_word_ready: got %0b, required 1", word_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (3) tick();
    checks++;
    if (nib_valid !== 1'b0 || word_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle: got nib_valid=%0b word_ready=%0b, required 0 and 1", nib_valid, word_ready);
    end
  endtask

  task automatic test_single();
    logic [31:0] w;
    logic [3:0]  tab [NIBBLES];
    logic [31:0] ws[$];
    int          good;
    bit          ok;
    w = 32'h8765_4321;
`ifdef NIBBLE_SER_MSB_FIRST_EN
    tab = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
`else
    tab = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
`endif
    nib_ready = 1'b1;
    ws.push_back(w);
    drive_words(ws);
    good = 0;
    for (int k = 0; k < NIBBLES; k++) begin
      checks++;
      if (nib_valid !== 1'b1 || nib_data !== tab[k] || nib_idx !== IDX_W'(k) || nib_last !== (k == NIBBLES-1)) begin
        failures++;
        $display("FAIL single_order[%0d]: got valid=%0b data=%h idx=%0d last=%0b, required valid=1 data=%h idx=%0d last=%0b",
                 k, nib_valid, nib_data, nib_idx, nib_last, tab[k], k, (k == NIBBLES-1));
      end
      tick();
    end
    checks++;
    if (nib_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_end: got nib_valid=%0b after last nibble, required 0", nib_valid);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_drain: got %0d nibbles still expected, required 0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ws[$];
    bit found;
    bit ok;
    nib_ready = 1'b1;
    ws.push_back(32'hefff_ffff);
    ws.push_back(32'h0000_0001);
    fork
      drive_words(ws);
      begin
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (nib_valid) begin
            found = 1'b1;
            break;
          end
        end
        checks++;
        if (!found) begin
          failures++;
          $display("FAIL b2b_start: got no nib_valid within 20 cycles, required first nibble");
        end
        for (int k = 0; k < 2*NIBBLES; k++) begin
          if (k != 0) @(negedge clk);
          checks++;
          if (nib_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap[%0d]: got nib_valid=%0b, required 1", k, nib_valid);
          end
          // Holding buffer is occupied from the second word's accept until
          // the first word's last nibble moves it into the active slot.
          checks++;
          if (word_ready !== !(k >= 1 && k <= NIBBLES-1)) begin
            failures++;
            $display("FAIL b2b_word_ready[%0d]: got %0b, required %0b", k, word_ready, !(k >= 1 && k <= NIBBLES-1));
          end
        end
      end
    join
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_drain: got %0d nibbles still expected, required 0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]      ws[$];
    logic [3:0]       pat;
    logic [3:0]       prev_d;
    logic [IDX_W-1:0] prev_i;
    bit               prev_v, prev_r, done;
    int               start_cnt;
    pat = 4'b1001;
    nib_ready = 1'b0;
    ws.push_back(32'ha5a5_a5a5);
    drive_words(ws);
    start_cnt = xfer_cnt;
    prev_v = 1'b0;
    prev_r = 1'b1;
    prev_d = '0;
    prev_i = '0;
    done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      nib_ready = pat[c % 4];
      @(negedge clk);
      if (prev_v && !prev_r) begin
        checks++;
        if (nib_valid !== 1'b1 || nib_data !== prev_d || nib_idx !== prev_i) begin
          failures++;
          $display("FAIL bp_hold[%0d]: got valid=%0b data=%h idx=%0d, required valid=1 data=%h idx=%0d",
                   c, nib_valid, nib_data, nib_idx, prev_d, prev_i);
        end
      end
      prev_v = nib_valid;
      prev_r = nib_ready;
      prev_d = nib_data;
      prev_i = nib_idx;
      tick();
      if (!nib_valid) begin
        done = 1'b1;
        break;
      end
    end
    nib_ready = 1'b1;
    checks++;
    if (!done || (xfer_cnt - start_cnt) != NIBBLES || sb_q.size() != 0) begin
      failures++;
      $display("FAIL bp_count: got %0d transfers (finished=%0b, %0d pending), required %0d",
               xfer_cnt - start_cnt, done, sb_q.size(), NIBBLES);
    end
  endtask

  task automatic test_full();
    logic [31:0] ws[$];
    bit found;
    bit ok;
    nib_ready = 1'b1;
    ws.push_back(32'h3210_fedc);
    ws.push_back(32'h89ab_cdef);
    ws.push_back(32'h5a5a_0f0f);
    fork
      drive_words(ws);
      begin
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (nib_valid && nib_ready && nib_last) begin
            found = 1'b1;
            break;
          end
        end
        checks++;
        if (!found || word_ready !== 1'b0 || word_valid !== 1'b1) begin
          failures++;
          $display("FAIL full_blocked: got last_seen=%0b word_ready=%0b word_valid=%0b, required 1 0 1",
                   found, word_ready, word_valid);
        end
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b1 || word_valid !== 1'b1 || word_data !== 32'h5a5a_0f0f) begin
          failures++;
          $display("FAIL full_release: got word_ready=%0b word_valid=%0b word_data=%h, required 1 1 5a5a0f0f",
                   word_ready, word_valid, word_data);
        end
        checks++;
        if (nib_idx !== '0 || nib_data !== exp_nib(32'h89ab_cdef, 0)) begin
          failures++;
          $display("FAIL full_handover: got idx=%0d data=%h, required idx=0 data=%h",
                   nib_idx, nib_data, exp_nib(32'h89ab_cdef, 0));
        end
      end
    join
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_drain: got %0d nibbles still expected, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ws[$];
    bit found;
    bit ok;
    nib_ready = 1'b1;
    ws.push_back(32'h1357_9bdf);
    drive_words(ws);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (nib_valid && nib_idx == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_mid_reach: got no idx 3 within 20 cycles, required idx 3");
    end
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    // Still before the next rising edge: the clear must be asynchronous.
    checks++;
    if (nib_valid !== 1'b0 || word_ready !== 1'b1 || nib_idx !== '0 || nib_last !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: got valid=%0b word_ready=%0b idx=%0d last=%0b, required 0 1 0 0",
               nib_valid, word_ready, nib_idx, nib_last);
    end
    sb_q.delete();
    tick();
    @(negedge clk);
    #2;
    reset  = 1'b1;
    mon_en = 1'b1;
    ws.delete();
    ws.push_back(32'h8765_4321);
    drive_words(ws);
    checks++;
    if (nib_valid !== 1'b1 || nib_idx !== '0 || nib_data !== exp_nib(32'h8765_4321, 0)) begin
      failures++;
      $display("FAIL rst_mid_restart: got valid=%0b idx=%0d data=%h, required valid=1 idx=0 data=%h",
               nib_valid, nib_idx, nib_data, exp_nib(32'h8765_4321, 0));
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_mid_drain: got %0d nibbles still expected, required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion by 200000 time units, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
